// File: rtl/dfc_mc_receiver.sv
// Multi-channel delayed-flow-control receiver.
// N virtual channels share one vld/data link; each channel has its own FIFO
// and fc_n back-pressure line. Channels merge onto one registered srdy/drdy
// output through a round-robin arbiter. Overflow and illegal-channel errors
// are sticky until err_clr.
module dfc_mc_receiver #(
   parameter int width    = 8,
   parameter int depth    = 8,
   parameter int channels = 2,
   parameter int skid     = 4,
   parameter int cw       = (channels > 1) ? $clog2(channels) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                c_vld,
   input  logic [cw-1:0]       c_chan,
   input  logic [width-1:0]    c_data,
   output logic [channels-1:0] c_fc_n,
   output logic                p_srdy,
   output logic [cw-1:0]       p_chan,
   output logic [width-1:0]    p_data,
   input  logic                p_drdy,
   output logic [channels-1:0] ovf,
   output logic                bad_chan,
   input  logic                err_clr
);

   localparam int asz = $clog2(depth);

   logic [width-1:0]    mem        [channels][depth];
   logic [asz:0]        wp         [channels];
   logic [asz:0]        rp         [channels];
   logic [asz:0]        count      [channels];
   logic [asz:0]        count_next [channels];
   logic [cw-1:0]       arb_ptr;
   logic [cw-1:0]       cand;
   logic [cw-1:0]       sel;
   logic [channels-1:0] push;
   logic [channels-1:0] pop;
   logic [channels-1:0] full_hit;
   logic [channels-1:0] fc_next;
   logic                load;
   logic                found;
   logic                bad_hit;

   // Occupancy, push/drop decisions, round-robin pick and next flow control
   always_comb begin
      load     = !p_srdy || p_drdy;
      bad_hit  = c_vld && (int'(c_chan) >= channels);
      found    = 1'b0;
      sel      = '0;
      cand     = '0;
      push     = '0;
      pop      = '0;
      full_hit = '0;
      fc_next  = '0;
      for (int unsigned i = 0; i < channels; i++) begin
         count[i]      = wp[i] - rp[i];
         count_next[i] = '0;
      end
      // Search from arb_ptr upward with wrap; only pre-edge contents count.
      for (int unsigned off = 0; off < channels; off++) begin
         cand = cw'((int'(arb_ptr) + int'(off)) % channels);
         if (!found && count[cand] != '0) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      for (int unsigned i = 0; i < channels; i++) begin
         // Fullness uses the pre-edge count even when the same edge pops.
         push[i]       = c_vld && (c_chan == cw'(i)) && (count[i] != (asz+1)'(depth));
         full_hit[i]   = c_vld && (c_chan == cw'(i)) && (count[i] == (asz+1)'(depth));
         pop[i]        = load && found && (sel == cw'(i));
         count_next[i] = count[i] + (asz+1)'(push[i]) - (asz+1)'(pop[i]);
         fc_next[i]    = (depth - int'(count_next[i])) > skid;
      end
   end

   // Channel FIFO storage (data only, not reset)
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < channels; i++) begin
         if (push[i]) begin
            mem[i][wp[i][asz-1:0]] <= c_data;
         end
      end
   end

   // Pointers, output register, arbiter pointer, flow control and error flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < channels; i++) begin
            wp[i] <= '0;
            rp[i] <= '0;
         end
         arb_ptr  <= '0;
         p_srdy   <= 1'b0;
         p_chan   <= '0;
         p_data   <= '0;
         c_fc_n   <= '0;
         ovf      <= '0;
         bad_chan <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < channels; i++) begin
            if (push[i]) wp[i] <= wp[i] + 1'b1;
            if (pop[i])  rp[i] <= rp[i] + 1'b1;
         end
         if (load) begin
            if (found) begin
               p_srdy  <= 1'b1;
               p_chan  <= sel;
               p_data  <= mem[sel][rp[sel][asz-1:0]];
               arb_ptr <= cw'((int'(sel) + 1) % channels);
            end else begin
               p_srdy  <= 1'b0;
            end
         end
         c_fc_n   <= fc_next;
         ovf      <= (ovf & ~{channels{err_clr}}) | full_hit;
         bad_chan <= (bad_chan & ~err_clr) | bad_hit;
      end
   end

endmodule

// File: tb/tb_dfc_mc_receiver.sv
// Randomized scoreboard bench for dfc_mc_receiver (3 channels so that an
// illegal channel id exists). A queue-based reference model predicts the
// output register, flow control and error flags each cycle; accepted beats
// are also pushed to per-channel scoreboards popped by the monitor on every
// output transfer.
module tb_dfc_mc_receiver;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int CH = 3;
   localparam int SK = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          c_vld;
   logic [CW-1:0] c_chan;
   logic [W-1:0]  c_data;
   logic [CH-1:0] c_fc_n;
   logic          p_srdy;
   logic [CW-1:0] p_chan;
   logic [W-1:0]  p_data;
   logic          p_drdy;
   logic [CH-1:0] ovf;
   logic          bad_chan;
   logic          err_clr;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state (value after the most recent edge)
   logic [W-1:0]  mq [CH][$];
   logic [W-1:0]  sb [CH][$];
   bit            m_vld;
   int            m_chan;
   logic [W-1:0]  m_data;
   int            m_ptr;
   bit [CH-1:0]   m_ovf;
   bit [CH-1:0]   m_fc;
   bit            m_bad;

   // sender's delayed view of c_fc_n (two register stages)
   logic [CH-1:0] d1, d2;

   dfc_mc_receiver #(.width(W), .depth(D), .channels(CH), .skid(SK)) dut (
      .clk(clk), .reset(reset), .c_vld(c_vld), .c_chan(c_chan), .c_data(c_data),
      .c_fc_n(c_fc_n), .p_srdy(p_srdy), .p_chan(p_chan), .p_data(p_data),
      .p_drdy(p_drdy), .ovf(ovf), .bad_chan(bad_chan), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         mq[i].delete();
         sb[i].delete();
      end
      m_vld = 0; m_chan = 0; m_data = '0; m_ptr = 0;
      m_ovf = '0; m_fc = '0; m_bad = 0;
   endtask

   // One clock edge of the receiver, from its rules, using the inputs held at that edge
   task automatic model_step();
      int pre [CH];
      int sel;
      bit [CH-1:0] nov;
      bit nbad;
      for (int i = 0; i < CH; i++) pre[i] = mq[i].size();
      if (!m_vld || p_drdy) begin
         sel = -1;
         for (int off = 0; off < CH; off++) begin
            int k;
            k = (m_ptr + off) % CH;
            if (sel < 0 && pre[k] > 0) sel = k;
         end
         if (sel >= 0) begin
            m_data = mq[sel].pop_front();
            m_chan = sel;
            m_vld  = 1;
            m_ptr  = (sel + 1) % CH;
         end else begin
            m_vld = 0;
         end
      end
      nov  = err_clr ? '0 : m_ovf;
      nbad = err_clr ? 1'b0 : m_bad;
      if (c_vld) begin
         if (int'(c_chan) >= CH) nbad = 1;
         else if (pre[c_chan] < D) begin
            mq[c_chan].push_back(c_data);
            sb[c_chan].push_back(c_data);
         end else nov[c_chan] = 1;
      end
      m_ovf = nov;
      m_bad = nbad;
      for (int i = 0; i < CH; i++) m_fc[i] = (D - mq[i].size()) > SK;
   endtask

   task automatic set_in(input bit v, input int ch, input int dat, input bit dr, input bit cl);
      c_vld   = v;
      c_chan  = CW'(ch);
      c_data  = W'(dat);
      p_drdy  = dr;
      err_clr = cl;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      if (reset) model_step();
      d2 = d1;
      d1 = c_fc_n;
   endtask

   // Monitor: per-cycle state comparison plus scoreboard pop on each transfer
   always @(negedge clk) begin
      int ch;
      logic [W-1:0] e;
      chk("p_srdy", p_srdy, m_vld);
      chk("p_chan", p_chan, m_chan);
      chk("p_data", p_data, m_data);
      chk("c_fc_n", c_fc_n, m_fc);
      chk("ovf", ovf, m_ovf);
      chk("bad_chan", bad_chan, m_bad);
      if (p_srdy && p_drdy) begin
         ch = int'(p_chan);
         if (ch >= CH || sb[ch].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: chan %0d data %0h with no expected beat", ch, p_data);
         end else begin
            e = sb[ch].pop_front();
            chk("sb_order", p_data, e);
         end
      end
   end

   initial begin
      reset = 1'b0;
      d1 = '0; d2 = '0;
      set_in(0, 0, 0, 1, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // idle after release: fc_n rises on the first edge
      repeat (2) begin set_in(0, 0, 0, 1, 0); cycle(); end

      // single beat, chan 1, visible one edge later
      set_in(1, 1, 8'h3C, 1, 0); cycle();
      repeat (3) begin set_in(0, 0, 0, 1, 0); cycle(); end

      // burst into chan 0 with output stalled, past overflow
      for (int i = 0; i < 10; i++) begin set_in(1, 0, 8'h10 + i, 0, 0); cycle(); end
      set_in(1, 1, 8'hA5, 0, 0); cycle();
      set_in(0, 0, 0, 0, 1); cycle();
      // illegal channel id
      set_in(1, 3, 8'hEE, 0, 0); cycle();
      set_in(0, 0, 0, 0, 1); cycle();
      // fill chan 1 too, then release the output
      for (int i = 0; i < 9; i++) begin set_in(1, 1, 8'h40 + i, 0, 0); cycle(); end
      repeat (25) begin set_in(0, 0, 0, 1, 0); cycle(); end

      // random traffic that ignores flow control
      repeat (600) begin
         int ch;
         ch = ($urandom % 16 == 0) ? 3 : int'($urandom_range(0, CH - 1));
         set_in(($urandom % 10) < 7, ch, $urandom, ($urandom % 10) < 4, ($urandom % 20) == 0);
         cycle();
      end

      // reset mid-traffic
      set_in(1, 0, 8'h77, 1, 0);
      @(posedge clk);
      #1;
      model_step();
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_fc_n", c_fc_n, '0);
      chk("async_srdy", p_srdy, 0);
      set_in(0, 0, 0, 1, 0);
      repeat (2) cycle();
      @(posedge clk);
      #1 reset = 1'b1;
      d1 = '0; d2 = '0;

      // sender obeys delayed flow control: no overflow expected
      repeat (1500) begin
         int ch;
         bit v;
         ch = int'($urandom_range(0, CH - 1));
         v = (($urandom % 10) < 8) && d2[ch];
         set_in(v, ch, $urandom, ($urandom % 10) < 6, 0);
         cycle();
      end
      chk("ovf_fc_obeyed", ovf, '0);

      // drain everything
      repeat (40) begin set_in(0, 0, 0, 1, 0); cycle(); end
      chk("drained_srdy", p_srdy, 0);
      for (int i = 0; i < CH; i++) chk("sb_leftover", sb[i].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
